// File: rtl/aes.sv
// Iterative AES-128 encryption core: one round per clock, key schedule expanded on the fly.
// Holds the forward S-box (a pure lookup, instantiated 20 times) and the top-level aes engine.

module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  // Byte 0x00 sits in the top bits, so entry x lives at bit offset (255 - x) * 8.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SboxTable[{~din, 3'b000} +: 8];
endmodule

module aes (
  input  logic         clk,
  input  logic         resetn,
  input  logic         data_valid_in,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic [127:0] res_enc_out,
  output logic         res_valid_out
);
  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e       fsm_q, fsm_d;
  logic [127:0] state_q, key_q;
  logic [3:0]   round_q;
  logic         load, step, last;
  logic [127:0] sb, sr, mc, key_next, rnd_out;
  logic [31:0]  sw, rot;
  logic [7:0]   rcon;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_subbytes
    aes_sbox u_sbox (.din(state_q[127-8*i -: 8]), .dout(sb[127-8*i -: 8]));
  end

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (.din(key_q[31-8*i -: 8]), .dout(sw[31-8*i -: 8]));
  end

  // Byte 4c+r is row r of column c; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  always_comb begin
    rcon = 8'h00;
    unique case (round_q)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // SubWord is taken before RotWord; the two commute since SubWord is bytewise.
  always_comb begin
    rot = {sw[23:0], sw[31:24]} ^ {rcon, 24'h0};
    key_next[127:96] = key_q[127:96] ^ rot;
    key_next[95:64]  = key_q[95:64] ^ key_next[127:96];
    key_next[63:32]  = key_q[63:32] ^ key_next[95:64];
    key_next[31:0]   = key_q[31:0] ^ key_next[63:32];
    rnd_out = ((round_q == 4'd10) ? sr : mc) ^ key_next;
  end

  always_ff @(posedge clk) begin
    if (resetn) fsm_q <= StIdle;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle:  if (load) fsm_d = StBusy;
      StBusy:  if (last) fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  always_comb begin
    load = (fsm_q == StIdle) && data_valid_in;
    step = (fsm_q == StBusy);
    last = step && (round_q == 4'd10);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q       <= '0;
      key_q         <= '0;
      round_q       <= '0;
      res_enc_out   <= '0;
      res_valid_out <= 1'b0;
    end else begin
      res_valid_out <= last;
      if (load) begin
        state_q <= data_in ^ key_in;
        key_q   <= key_in;
        round_q <= 4'd1;
      end else if (step) begin
        state_q <= rnd_out;
        key_q   <= key_next;
        round_q <= last ? 4'd0 : round_q + 4'd1;
      end
      if (last) res_enc_out <= rnd_out;
    end
  end
endmodule

// File: tb/tb_aes.sv
// Bench for aes: directed FIPS-197 vectors plus random blocks, scored by a monitor process
// against a byte-array AES model whose S-box is derived from the GF(2^8) inverse.

module tb_aes;
  logic         clk = 1'b0;
  logic         resetn;
  logic         data_valid_in;
  logic [127:0] data_in, key_in;
  logic [127:0] res_enc_out;
  logic         res_valid_out;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         cnt = 0;
  bit         tb_done = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] sbox_t[256];

  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ZCt   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_valid_in(data_valid_in),
    .data_in      (data_in),
    .key_in       (key_in),
    .res_enc_out  (res_enc_out),
    .res_valid_out(res_valid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s[16], rk[16], t[16], tmp[4];
    logic [7:0] rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      rk[i] = key[127-8*i -: 8];
      s[i]  = pt[127-8*i -: 8] ^ rk[i];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = sbox_t[s[4*((c+w)%4)+w]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          s[4*c+w] = (r == 10) ? t[4*c+w] :
                     gmul(8'h02, t[4*c+w]) ^ gmul(8'h03, t[4*c+(w+1)%4])
                     ^ t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
      tmp[0] = sbox_t[rk[13]] ^ rc;
      tmp[1] = sbox_t[rk[14]];
      tmp[2] = sbox_t[rk[15]];
      tmp[3] = sbox_t[rk[12]];
      for (int i = 0; i < 4; i++) rk[i] ^= tmp[i];
      for (int i = 4; i < 16; i++) rk[i] ^= rk[i-4];
      for (int i = 0; i < 16; i++) s[i] ^= rk[i];
      rc = gmul(rc, 8'h02);
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [127:0] pt, input logic [127:0] key,
                       input logic [127:0] ex, input bit push);
    data_valid_in = 1'b1;
    data_in       = pt;
    key_in        = key;
    if (push) sb_q.push_back('{data: ex, cyc: cnt});
    step();
    data_valid_in = 1'b0;
  endtask

  // Ten busy cycles with scrambled inputs and stray start strobes that must be ignored.
  task automatic busy_noise();
    for (int j = 0; j < 10; j++) begin
      data_in       = {$urandom, $urandom, $urandom, $urandom};
      key_in        = {$urandom, $urandom, $urandom, $urandom};
      data_valid_in = ($urandom_range(0, 3) == 0);
      step();
    end
    data_valid_in = 1'b0;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cnt, act, exp);
    end
  endtask

  // Monitor: every cycle the pulse must match the scoreboard head (due 11 cycles after the
  // drive cycle) and res_enc_out must equal the last result, or zero after reset.
  initial begin
    bit           rst_at_edge = 1'b0;
    bit           hold_known  = 1'b0;
    bit           exp_v;
    logic [127:0] hold_exp = '0;
    exp_t         e;
    while (!tb_done) begin
      @(negedge clk);
      if (rst_at_edge) begin
        chk("reset_valid", 128'(res_valid_out), 128'(0));
        chk("reset_data", res_enc_out, 128'h0);
        hold_exp   = '0;
        hold_known = 1'b1;
      end else begin
        exp_v = (sb_q.size() > 0) && (cnt - sb_q[0].cyc == 11);
        chk("valid_pulse", 128'(res_valid_out), 128'(exp_v));
        if (exp_v) begin
          e        = sb_q.pop_front();
          hold_exp = e.data;
        end
        if (hold_known) chk("result_data", res_enc_out, hold_exp);
      end
      rst_at_edge = resetn;
    end
    chk("queue_drained", 128'(sb_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    build_sbox();
    resetn        = 1'b1;
    data_valid_in = 1'b0;
    data_in       = '0;
    key_in        = '0;
    repeat (3) step();
    resetn = 1'b0;
    step();

    issue(C1Pt, C1Key, C1Ct, 1'b1);
    repeat (12) step();
    issue(BPt, BKey, BCt, 1'b1);
    repeat (12) step();
    issue('0, '0, ZCt, 1'b1);
    repeat (12) step();

    // Strobe with the App. B vector in the fifth cycle of a C.1 run.
    issue(C1Pt, C1Key, C1Ct, 1'b1);
    repeat (3) step();
    data_valid_in = 1'b1;
    data_in       = BPt;
    key_in        = BKey;
    step();
    data_valid_in = 1'b0;
    repeat (20) step();

    // Abort C.1 with reset in its sixth cycle, then run App. B.
    issue(C1Pt, C1Key, C1Ct, 1'b0);
    repeat (4) step();
    resetn = 1'b1;
    step();
    resetn = 1'b0;
    repeat (15) step();
    issue(BPt, BKey, BCt, 1'b1);
    repeat (12) step();

    // Back-to-back: next start issued in the pulse cycle.
    issue(C1Pt, C1Key, C1Ct, 1'b1);
    for (int i = 0; i < 20 && !res_valid_out; i++) step();
    issue('0, '0, ZCt, 1'b1);
    repeat (12) step();

    for (int n = 0; n < 100; n++) begin
      logic [127:0] pt, key;
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      issue(pt, key, aes_ref(pt, key), 1'b1);
      busy_noise();
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (15) step();
    tb_done = 1'b1;
  end
endmodule
